// File: rtl/mar_burst_if.sv
// Bus bundle between the control unit and the memory address register.
interface mar_burst_if #(
  parameter int ADDR_W  = 4,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]  d_in;
  logic [ADDR_W-1:0]  pc_in;
  logic               sel;
  logic               ld_n;
  logic               inc;
  logic               dir;
  logic [BURST_W-1:0] burst_len;
  logic               burst_start;
  logic               burst_ack;
  logic [ADDR_W-1:0]  mar_out;
  logic               burst_busy;
  logic               burst_done;
  logic               wrap;

  modport master (
    output d_in, pc_in, sel, ld_n, inc, dir, burst_len, burst_start, burst_ack,
    input  mar_out, burst_busy, burst_done, wrap
  );

  modport slave (
    input  d_in, pc_in, sel, ld_n, inc, dir, burst_len, burst_start, burst_ack,
    output mar_out, burst_busy, burst_done, wrap
  );
endinterface

// File: rtl/mar_burst.sv
// Memory address register with up/down stepping that wraps at DEPTH and a
// counted burst sequencer driven by memory acks.
module mar_burst #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int BURST_W = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  mar_burst_if.slave    bus
);
  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_X  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [ADDR_W:0]    step_res;
  logic               step_dn;

  // Returns {wrap, next_addr}; out-of-range addresses fold back into range.
  function automatic logic [ADDR_W:0] step_f(input logic [ADDR_W-1:0] a,
                                             input logic down);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    if (!down) begin
      if (ax >= LAST_X) return {1'b1, {ADDR_W{1'b0}}};
      return {1'b0, a + 1'b1};
    end
    if (a == '0 || ax >= DEPTH_X) return {1'b1, LAST};
    return {1'b0, a - 1'b1};
  endfunction

  assign step_dn  = (state_q == BURST) ? dir_q : bus.dir;
  assign step_res = step_f(addr_q, step_dn);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (!bus.ld_n) begin
      addr_d  = bus.sel ? bus.pc_in : bus.d_in;
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.burst_start) begin
            dir_d = bus.dir;
            if (bus.burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              rem_d   = bus.burst_len;
              state_d = BURST;
            end
          end else if (bus.inc) begin
            addr_d = step_res[ADDR_W-1:0];
            wrap_d = step_res[ADDR_W];
          end
        end
        BURST: begin
          if (bus.burst_ack) begin
            addr_d = step_res[ADDR_W-1:0];
            wrap_d = step_res[ADDR_W];
            rem_d  = rem_q - 1'b1;
            if (rem_q == BURST_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.mar_out    = addr_q;
  assign bus.burst_busy = (state_q == BURST);
  assign bus.burst_done = done_q;
  assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_mar_burst.sv
// Bench for mar_burst: directed scenarios plus randomized traffic against a
// behavioural model of address, burst count and event pulses.
module tb_mar_burst;
  localparam int AW = 4;
  localparam int D  = 12;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  mar_burst_if #(.ADDR_W(AW), .BURST_W(BW)) bif();
  mar_burst #(.ADDR_W(AW), .DEPTH(D), .BURST_W(BW)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  // Model: address as an integer, burst as "accesses still owed".
  int m_addr = 0, m_rem = 0;
  bit m_busy = 0, m_dir = 0, m_done = 0, m_wrap = 0;

  function automatic logic [AW+2:0] exp_v();
    return {AW'(m_addr), m_busy, m_done, m_wrap};
  endfunction

  function automatic logic [AW+2:0] obs_v();
    return {bif.mar_out, bif.burst_busy, bif.burst_done, bif.wrap};
  endfunction

  task automatic idle_in();
    bif.ld_n = 1'b1; bif.sel = 1'b0; bif.d_in = '0; bif.pc_in = '0;
    bif.inc = 1'b0; bif.dir = 1'b0; bif.burst_len = '0;
    bif.burst_start = 1'b0; bif.burst_ack = 1'b0;
  endtask

  task automatic tick();
    int a, r; bit b, dr, dn, w, down;
    a = m_addr; r = m_rem; b = m_busy; dr = m_dir; dn = 0; w = 0;
    if (!clr_n) begin
      a = 0; r = 0; b = 0; dr = 0;
    end else if (!bif.ld_n) begin
      a = bif.sel ? int'(bif.pc_in) : int'(bif.d_in); r = 0; b = 0;
    end else if ((!b && !bif.burst_start && bif.inc) || (b && bif.burst_ack)) begin
      down = b ? dr : bif.dir;
      if (!down) begin
        w = (a >= D - 1); a = w ? 0 : a + 1;
      end else begin
        w = (a == 0 || a >= D); a = w ? D - 1 : a - 1;
      end
      if (b) begin
        r--;
        if (r == 0) begin b = 0; dn = 1; end
      end
    end else if (!b && bif.burst_start) begin
      dr = bif.dir;
      if (bif.burst_len == 0) dn = 1;
      else begin r = int'(bif.burst_len); b = 1; end
    end
    @(posedge clk); #1;
    m_addr = a; m_rem = r; m_busy = b; m_dir = dr; m_done = dn; m_wrap = w;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; idle_in();
    repeat (2) tick();
    checks++;
    if (obs_v() !== '0)
      begin errors++; $display("FAIL reset: got %h want 0", obs_v()); end
    clr_n = 1'b1;
  endtask

  task automatic test_load();
    bif.ld_n = 1'b0; bif.sel = 1'b0; bif.d_in = 4'd9; bif.pc_in = 4'd2;
    tick();
    checks++;
    if (bif.mar_out !== 4'd9)
      begin errors++; $display("FAIL load_d: got %0d want 9", bif.mar_out); end
    bif.sel = 1'b1; bif.pc_in = 4'd3;
    tick();
    checks++;
    if (obs_v() !== {4'd3, 3'b000})
      begin errors++; $display("FAIL load_pc: got %h want %h", obs_v(), {4'd3, 3'b000}); end
    idle_in();
  endtask

  task automatic test_wrap();
    logic [AW+2:0] want [5];
    want = '{{4'd11, 3'b000}, {4'd0, 3'b001}, {4'd11, 3'b001}, {4'd14, 3'b000}, {4'd0, 3'b001}};
    bif.ld_n = 1'b0; bif.d_in = 4'd10; tick();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      idle_in();
      case (i)
        0, 1: bif.inc = 1'b1;
        2:    begin bif.inc = 1'b1; bif.dir = 1'b1; end
        3:    begin bif.ld_n = 1'b0; bif.d_in = 4'd14; end
        default: bif.inc = 1'b1;
      endcase
      tick();
      checks++;
      if (obs_v() !== want[i])
        begin errors++; $display("FAIL wrap[%0d]: got %h want %h", i, obs_v(), want[i]); end
    end
    idle_in(); tick();
    checks++;
    if (bif.wrap !== 1'b0)
      begin errors++; $display("FAIL wrap_clear: got %b want 0", bif.wrap); end
  endtask

  task automatic test_burst_gaps();
    bit acks [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [AW+2:0] want [4];
    want = '{{4'd6, 3'b100}, {4'd6, 3'b100}, {4'd7, 3'b100}, {4'd8, 3'b010}};
    bif.ld_n = 1'b0; bif.d_in = 4'd5; tick();
    idle_in(); bif.burst_start = 1'b1; bif.burst_len = 4'd3; tick();
    checks++;
    if (obs_v() !== {4'd5, 3'b100})
      begin errors++; $display("FAIL burst_start: got %h want %h", obs_v(), {4'd5, 3'b100}); end
    for (int i = 0; i < 4; i++) begin
      idle_in(); bif.burst_ack = acks[i]; tick();
      checks++;
      if (obs_v() !== want[i])
        begin errors++; $display("FAIL burst_gap[%0d]: got %h want %h", i, obs_v(), want[i]); end
    end
    idle_in(); tick();
    checks++;
    if (obs_v() !== {4'd8, 3'b000})
      begin errors++; $display("FAIL burst_done_clear: got %h want %h", obs_v(), {4'd8, 3'b000}); end
  endtask

  task automatic test_zero_burst();
    bif.burst_start = 1'b1; bif.burst_len = '0; bif.burst_ack = 1'b1; tick();
    checks++;
    if (obs_v() !== {4'd8, 3'b010})
      begin errors++; $display("FAIL zero_burst: got %h want %h", obs_v(), {4'd8, 3'b010}); end
    idle_in(); tick();
    checks++;
    if (obs_v() !== {4'd8, 3'b000})
      begin errors++; $display("FAIL zero_burst_clear: got %h want %h", obs_v(), {4'd8, 3'b000}); end
  endtask

  task automatic test_abort();
    bif.ld_n = 1'b0; bif.d_in = 4'd2; tick();
    idle_in(); bif.burst_start = 1'b1; bif.burst_len = 4'd8; tick();
    idle_in(); bif.burst_ack = 1'b1; bif.inc = 1'b1; bif.dir = 1'b1; tick(); tick();
    idle_in(); bif.inc = 1'b1; bif.burst_start = 1'b1; tick();
    checks++;
    if (obs_v() !== {4'd4, 3'b100})
      begin errors++; $display("FAIL abort_mid: got %h want %h", obs_v(), {4'd4, 3'b100}); end
    idle_in(); bif.ld_n = 1'b0; bif.d_in = 4'd7; bif.burst_ack = 1'b1; tick();
    checks++;
    if (obs_v() !== {4'd7, 3'b000})
      begin errors++; $display("FAIL abort_load: got %h want %h", obs_v(), {4'd7, 3'b000}); end
    idle_in(); tick();
    checks++;
    if (bif.burst_done !== 1'b0)
      begin errors++; $display("FAIL abort_no_done: got %b want 0", bif.burst_done); end
  endtask

  task automatic test_reset_mid();
    bif.burst_start = 1'b1; bif.burst_len = 4'd5; bif.dir = 1'b1; tick();
    idle_in(); bif.burst_ack = 1'b1; tick();
    checks++;
    if (obs_v() !== {4'd6, 3'b100})
      begin errors++; $display("FAIL rst_mid_pre: got %h want %h", obs_v(), {4'd6, 3'b100}); end
    clr_n = 1'b0; bif.ld_n = 1'b0; bif.d_in = 4'd9; tick();
    checks++;
    if (obs_v() !== '0)
      begin errors++; $display("FAIL rst_mid: got %h want 0", obs_v()); end
    clr_n = 1'b1; idle_in(); bif.burst_ack = 1'b1; tick();
    checks++;
    if (obs_v() !== '0)
      begin errors++; $display("FAIL rst_mid_after: got %h want 0", obs_v()); end
  endtask

  task automatic test_back_to_back();
    idle_in(); bif.burst_start = 1'b1; bif.burst_len = 4'd2; tick();
    idle_in(); bif.burst_ack = 1'b1; tick(); tick();
    checks++;
    if (obs_v() !== {4'd2, 3'b010})
      begin errors++; $display("FAIL b2b_done: got %h want %h", obs_v(), {4'd2, 3'b010}); end
    bif.burst_ack = 1'b0; bif.burst_start = 1'b1; bif.burst_len = 4'd1; bif.dir = 1'b1; tick();
    idle_in(); bif.burst_ack = 1'b1;
    checks++;
    if (obs_v() !== {4'd2, 3'b100})
      begin errors++; $display("FAIL b2b_restart: got %h want %h", obs_v(), {4'd2, 3'b100}); end
    tick();
    checks++;
    if (obs_v() !== {4'd1, 3'b010})
      begin errors++; $display("FAIL b2b_second: got %h want %h", obs_v(), {4'd1, 3'b010}); end
    idle_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      clr_n           = ($urandom_range(99) >= 2);
      bif.ld_n        = ($urandom_range(99) >= 7);
      bif.sel         = $urandom_range(1);
      bif.d_in        = AW'($urandom_range(15));
      bif.pc_in       = AW'($urandom_range(15));
      bif.inc         = ($urandom_range(99) < 40);
      bif.dir         = $urandom_range(1);
      bif.burst_len   = BW'($urandom_range(15));
      bif.burst_start = ($urandom_range(99) < 15);
      bif.burst_ack   = ($urandom_range(99) < 60);
      tick();
      checks++;
      if (obs_v() !== exp_v())
        begin errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_v(), exp_v()); end
    end
    clr_n = 1'b1; idle_in();
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_burst_gaps();
    test_zero_burst();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
